// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one single-port synchronous SRAM (1-cycle read latency) between the
// instruction-fetch port (I, read only) and the data port (D, read/write).
// The grant is evaluated combinationally every cycle, so the winner sees
// addr_ok in the same cycle it requests. A small FSM remembers which port
// owns the data phase of the access issued in the previous cycle and routes
// sram_rdata back to that port. One access per cycle, no bubbles.
module sram_port_arbiter #(
    parameter int RR_MODE    = 0,   // 0: D priority + I anti-starvation, 1: round-robin
    parameter int MAX_STARVE = 4    // contested cycles I may lose before it is forced to win
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam int CW = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(MAX_STARVE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   starve_cnt_r;
    logic [CW-1:0]   starve_cnt_nxt_s;
    logic            last_grant_i_r;     // 1: last grant went to I, 0: to D
    logic            last_grant_i_nxt_s;
    logic            d_wr_r;             // outstanding D access is a write
    logic            d_wr_nxt_s;
    logic            grant_i_s;
    logic            grant_d_s;

    // Saturating increment of the starvation counter.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
        logic [CW-1:0] res;
        if (cnt >= STARVE_MAX) begin
            res = STARVE_MAX;
        end else begin
            res = cnt + CW'(1);
        end
        return res;
    endfunction

    // Per-cycle grant decision; nothing is granted while reset is held.
    always_comb begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if (rst) begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end else if (i_req && d_req) begin
            if (RR_MODE != 0) begin
                grant_i_s = ~last_grant_i_r;
            end else begin
                grant_i_s = (starve_cnt_r == STARVE_MAX);
            end
            grant_d_s = ~grant_i_s;
        end else begin
            grant_i_s = i_req;
            grant_d_s = d_req;
        end
    end

    // Next-state logic: data-phase owner, starvation counter, last winner.
    always_comb begin
        state_nxt_s        = IDLE;
        starve_cnt_nxt_s   = starve_cnt_r;
        last_grant_i_nxt_s = last_grant_i_r;
        d_wr_nxt_s         = 1'b0;

        if (grant_i_s) begin
            state_nxt_s        = RESP_I;
            last_grant_i_nxt_s = 1'b1;
        end else if (grant_d_s) begin
            state_nxt_s        = RESP_D;
            last_grant_i_nxt_s = 1'b0;
            d_wr_nxt_s         = d_wr;
        end else begin
            state_nxt_s        = IDLE;
            last_grant_i_nxt_s = last_grant_i_r;
        end

        if (RR_MODE != 0) begin
            starve_cnt_nxt_s = '0;
        end else if (grant_i_s) begin
            starve_cnt_nxt_s = '0;
        end else if (grant_d_s && i_req) begin
            starve_cnt_nxt_s = sat_inc(starve_cnt_r);
        end else begin
            starve_cnt_nxt_s = starve_cnt_r;
        end
    end

    // State registers; reset drops any outstanding access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            starve_cnt_r   <= '0;
            last_grant_i_r <= 1'b0;
            d_wr_r         <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            starve_cnt_r   <= starve_cnt_nxt_s;
            last_grant_i_r <= last_grant_i_nxt_s;
            d_wr_r         <= d_wr_nxt_s;
        end
    end

    // Address phase: the winner drives the SRAM and sees addr_ok this cycle.
    always_comb begin
        i_addr_ok  = grant_i_s;
        d_addr_ok  = grant_d_s;
        sram_en    = grant_i_s | grant_d_s;
        sram_we    = 4'h0;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        if (grant_i_s) begin
            sram_addr = i_addr;
        end else if (grant_d_s) begin
            sram_addr  = d_addr;
            sram_wdata = d_wdata;
            sram_we    = d_wr ? d_wstrb : 4'h0;
        end else begin
            sram_addr = 32'h0;
        end
    end

    // Data phase: route SRAM read data to the owner; the other port sees 0.
    always_comb begin
        i_data_ok = 1'b0;
        i_rdata   = 32'h0;
        d_data_ok = 1'b0;
        d_rdata   = 32'h0;
        if (rst) begin
            i_data_ok = 1'b0;
            d_data_ok = 1'b0;
        end else begin
            case (state_r)
                RESP_I: begin
                    i_data_ok = 1'b1;
                    i_rdata   = sram_rdata;
                end
                RESP_D: begin
                    d_data_ok = 1'b1;
                    d_rdata   = d_wr_r ? 32'h0 : sram_rdata;
                end
                default: begin
                    i_data_ok = 1'b0;
                    d_data_ok = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: one fixed-priority instance (fp) and one
// round-robin instance (rr), each with its own behavioural SRAM. Expected
// responses are queued when a grant is checked and consumed by a monitor.
module tb_sram_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        i_req0, d_req0, i_req1, d_req1;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        d_wr;
    logic [3:0]  d_wstrb;

    logic        i_addr_ok0, i_data_ok0, d_addr_ok0, d_data_ok0, sram_en0;
    logic [31:0] i_rdata0, d_rdata0, sram_addr0, sram_wdata0, srd0;
    logic [3:0]  sram_we0;
    logic        i_addr_ok1, i_data_ok1, d_addr_ok1, d_data_ok1, sram_en1;
    logic [31:0] i_rdata1, d_rdata1, sram_addr1, sram_wdata1, srd1;
    logic [3:0]  sram_we1;

    sram_port_arbiter #(.RR_MODE(0), .MAX_STARVE(4)) dut_fp (
        .clk(clk), .rst(rst),
        .i_req(i_req0), .i_addr(i_addr), .i_addr_ok(i_addr_ok0),
        .i_data_ok(i_data_ok0), .i_rdata(i_rdata0),
        .d_req(d_req0), .d_wr(d_wr), .d_wstrb(d_wstrb), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok0), .d_data_ok(d_data_ok0),
        .d_rdata(d_rdata0), .sram_en(sram_en0), .sram_we(sram_we0),
        .sram_addr(sram_addr0), .sram_wdata(sram_wdata0), .sram_rdata(srd0)
    );

    sram_port_arbiter #(.RR_MODE(1), .MAX_STARVE(4)) dut_rr (
        .clk(clk), .rst(rst),
        .i_req(i_req1), .i_addr(i_addr), .i_addr_ok(i_addr_ok1),
        .i_data_ok(i_data_ok1), .i_rdata(i_rdata1),
        .d_req(d_req1), .d_wr(d_wr), .d_wstrb(d_wstrb), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok1), .d_data_ok(d_data_ok1),
        .d_rdata(d_rdata1), .sram_en(sram_en1), .sram_we(sram_we1),
        .sram_addr(sram_addr1), .sram_wdata(sram_wdata1), .sram_rdata(srd1)
    );

    // Behavioural SRAMs (word index from addr[11:2]) with a preload port.
    logic        pl_en = 1'b0;
    logic [9:0]  pl_a;
    logic [31:0] pl_d;
    logic [31:0] mem0 [0:1023];
    logic [31:0] mem1 [0:1023];

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = w[b*8 +: 8];
        end
        return r;
    endfunction

    // SRAM model for the fixed-priority instance.
    always @(posedge clk) begin
        if (pl_en) begin
            mem0[pl_a] <= pl_d;
        end else if (sram_en0) begin
            srd0 <= mem0[sram_addr0[11:2]];
            if (|sram_we0) mem0[sram_addr0[11:2]] <= merge(mem0[sram_addr0[11:2]], sram_wdata0, sram_we0);
        end
    end

    // SRAM model for the round-robin instance.
    always @(posedge clk) begin
        if (pl_en) begin
            mem1[pl_a] <= pl_d;
        end else if (sram_en1) begin
            srd1 <= mem1[sram_addr1[11:2]];
            if (|sram_we1) mem1[sram_addr1[11:2]] <= merge(mem1[sram_addr1[11:2]], sram_wdata1, sram_we1);
        end
    end

    typedef struct {
        int          port;   // 1: I, 2: D
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc    = 0;
    int   tests  = 0;
    int   failed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: consume expected responses whenever a data_ok appears.
    task automatic mon(input int which, input logic iok, input logic dok,
                       input logic [31:0] ird, input logic [31:0] drd);
        exp_t  e;
        bit    have;
        string p;
        p    = (which == 0) ? "fp" : "rr";
        have = (which == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (iok && dok) chk($sformatf("%s_both_data_ok", p), 32'd1, 32'd0);
        if (iok || dok) begin
            if (!have) begin
                chk($sformatf("%s_unexpected_data_ok", p), {30'd0, dok, iok}, 32'd0);
            end else begin
                if (which == 0) e = q0.pop_front();
                else            e = q1.pop_front();
                chk($sformatf("%s_resp_port", p), iok ? 32'd1 : 32'd2, 32'(e.port));
                chk($sformatf("%s_resp_cycle", p), 32'(cyc), 32'(e.cyc));
                chk($sformatf("%s_resp_data", p), iok ? ird : drd, e.data);
                chk($sformatf("%s_nonowner_rdata", p), iok ? drd : ird, 32'd0);
            end
        end else if (have) begin
            if (which == 0) e = q0[0];
            else            e = q1[0];
            if (e.cyc <= cyc) begin
                chk($sformatf("%s_missing_data_ok", p), 32'd0, 32'(e.port));
                if (which == 0) void'(q0.pop_front());
                else            void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, i_data_ok0, d_data_ok0, i_rdata0, d_rdata0);
            mon(1, i_data_ok1, d_data_ok1, i_rdata1, d_rdata1);
        end
    end

    // Check the address phase of one instance; e: 0 none, 1 I, 2 D.
    task automatic chk_grant(input int which, input int e, input logic iok, input logic dok,
                             input logic en, input logic [3:0] we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic dw, input logic [3:0] ds,
                             input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dd,
                             input logic [31:0] ix, input logic [31:0] dx, input bit resp);
        exp_t  x;
        string p;
        p = (which == 0) ? "fp" : "rr";
        chk($sformatf("%s_i_addr_ok", p), 32'(iok), 32'(e == 1));
        chk($sformatf("%s_d_addr_ok", p), 32'(dok), 32'(e == 2));
        chk($sformatf("%s_sram_en", p), 32'(en), 32'(e != 0));
        chk($sformatf("%s_sram_we", p), 32'(we), (e == 2 && dw) ? 32'(ds) : 32'd0);
        chk($sformatf("%s_sram_addr", p), addr, (e == 1) ? ia : ((e == 2) ? da : 32'd0));
        chk($sformatf("%s_sram_wdata", p), wdata, (e == 2) ? dd : 32'd0);
        if (e != 0 && resp) begin
            x.port = e;
            x.data = (e == 1) ? ix : (dw ? 32'd0 : dx);
            x.cyc  = cyc + 1;
            if (which == 0) q0.push_back(x);
            else            q1.push_back(x);
        end
    endtask

    // One cycle of stimulus on both instances; entered and left at posedge+1.
    task automatic cyc_drive(input logic ir0, input logic dr0, input logic ir1, input logic dr1,
                             input logic dw, input logic [3:0] ds, input logic [31:0] ia,
                             input logic [31:0] da, input logic [31:0] dd,
                             input logic [31:0] ix, input logic [31:0] dx,
                             input int e0, input int e1, input bit resp);
        i_req0 = ir0; d_req0 = dr0; i_req1 = ir1; d_req1 = dr1;
        i_addr = ia; d_addr = da; d_wdata = dd; d_wr = dw; d_wstrb = ds;
        @(negedge clk);
        chk_grant(0, e0, i_addr_ok0, d_addr_ok0, sram_en0, sram_we0, sram_addr0, sram_wdata0,
                  dw, ds, ia, da, dd, ix, dx, resp);
        chk_grant(1, e1, i_addr_ok1, d_addr_ok1, sram_en1, sram_we1, sram_addr1, sram_wdata1,
                  dw, ds, ia, da, dd, ix, dx, resp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc_drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0,
                  32'h0, 32'h0, 0, 0, 1'b1);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pl_en = 1'b1;
        pl_a  = a[11:2];
        pl_d  = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_fp"}, 32'(|{i_addr_ok0, i_data_ok0, i_rdata0, d_addr_ok0, d_data_ok0,
                                 d_rdata0, sram_en0, sram_we0, sram_addr0, sram_wdata0}), 32'd0);
        chk({name, "_rr"}, 32'(|{i_addr_ok1, i_data_ok1, i_rdata1, d_addr_ok1, d_data_ok1,
                                 d_rdata1, sram_en1, sram_we1, sram_addr1, sram_wdata1}), 32'd0);
    endtask

    localparam logic [31:0] IA  = 32'h1c000000;
    localparam logic [31:0] IW  = 32'h02800421;
    localparam logic [31:0] DA  = 32'h00000040;
    localparam logic [31:0] DW  = 32'h11110000;

    initial begin
        // Test 1: reset with both requests asserted; all outputs must be 0.
        rst = 1'b1;
        i_req0 = 1'b1; d_req0 = 1'b1; i_req1 = 1'b1; d_req1 = 1'b1;
        i_addr = IA; d_addr = DA; d_wdata = 32'h55aa55aa; d_wr = 1'b1; d_wstrb = 4'hf;
        @(posedge clk);
        #1;
        preload(IA, IW);
        preload(DA, DW);
        preload(32'h100, 32'h0);
        preload(32'h200, 32'ha5a5a5a5);
        chk_zero("rst_outputs");
        d_wr = 1'b0;
        rst  = 1'b0;
        cyc_drive(1, 1, 0, 0, 1'b0, 4'h0, IA, DA, 32'h0, IW, DW, 2, 0, 1'b1);
        idle();

        // Test 2: I read alone.
        cyc_drive(1, 0, 0, 0, 1'b0, 4'h0, IA, 32'h0, 32'h0, IW, 32'h0, 1, 0, 1'b1);
        idle();

        // Test 3: partial D writes followed by read-back.
        cyc_drive(0, 1, 0, 0, 1'b1, 4'b0011, 32'h0, 32'h100, 32'hdeadbeef, 32'h0, 32'h0, 2, 0, 1'b1);
        cyc_drive(0, 1, 0, 0, 1'b0, 4'h0, 32'h0, 32'h100, 32'h0, 32'h0, 32'h0000beef, 2, 0, 1'b1);
        cyc_drive(0, 1, 0, 0, 1'b1, 4'b1100, 32'h0, 32'h200, 32'h11223344, 32'h0, 32'h0, 2, 0, 1'b1);
        cyc_drive(0, 1, 0, 0, 1'b0, 4'h0, 32'h0, 32'h200, 32'h0, 32'h0, 32'h1122a5a5, 2, 0, 1'b1);
        idle();

        // Test 4: fixed priority with anti-starvation: D,D,D,D,I,D,D,D,D,I.
        for (int k = 0; k < 10; k++) begin
            cyc_drive(1, 1, 0, 0, 1'b0, 4'h0, IA, DA, 32'h0, IW, DW,
                      (k == 4 || k == 9) ? 1 : 2, 0, 1'b1);
        end
        idle();

        // Test 5: round-robin, both held: I,D,I,D,I,D.
        for (int k = 0; k < 6; k++) begin
            cyc_drive(0, 0, 1, 1, 1'b0, 4'h0, IA, DA, 32'h0, IW, DW,
                      0, (k % 2 == 0) ? 1 : 2, 1'b1);
        end
        idle();

        // Test 6: reset pulse in the cycle after an I grant drops the access.
        cyc_drive(1, 0, 1, 0, 1'b0, 4'h0, IA, 32'h0, 32'h0, IW, 32'h0, 1, 1, 1'b0);
        i_req0 = 1'b0; d_req0 = 1'b0; i_req1 = 1'b0; d_req1 = 1'b0;
        rst = 1'b1;
        #2;
        chk_zero("rst_pulse_outputs");
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        // After reset: fp D wins (starve 0), rr I wins (last_grant back to D).
        cyc_drive(1, 1, 1, 1, 1'b0, 4'h0, IA, DA, 32'h0, IW, DW, 2, 1, 1'b1);
        idle();
        idle();

        chk("fp_queue_drained", 32'(q0.size()), 32'd0);
        chk("rr_queue_drained", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
